// File: rtl/ghost_scheduler_if.sv
// ghost_scheduler_if: control inputs and sprite status outputs of the ghost scheduler.
interface ghost_scheduler_if #(parameter int N_GHOSTS = 3);
  logic start, stop, collision;
  logic [25:0] speed_offset;
  logic [N_GHOSTS-1:0] move_tick, active;
  logic [1:0] state;
  modport master (output start, stop, collision, speed_offset, input move_tick, active, state);
  modport slave (input start, stop, collision, speed_offset, output move_tick, active, state);
endinterface

// File: rtl/ghost_scheduler.sv
// ghost_scheduler: staggered ghost spawning and per-ghost move strobes on a speed-dependent period.
// Collision freeze is built only when GHOST_SCHED_FREEZE_EN is defined.
module ghost_scheduler #(
  parameter int N_GHOSTS = 3,
  parameter int TIME_MAX = 4000000,
  parameter int MIN_PERIOD = 1000,
  parameter int SPAWN_DELAY = 25000000,
  parameter int FREEZE_CYCLES = 50000000
) (
  input logic clk,
  input logic reset_n,
  ghost_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SPAWN, RUN, FREEZE} state_t;
  localparam int PW = $clog2(TIME_MAX + 1);
  localparam int SW = $clog2(SPAWN_DELAY + 1);
  state_t st;
  logic [N_GHOSTS-1:0] active, tick, sel, sel_n;
  logic [PW-1:0] pc, period_q, period_calc, cur_period;
  logic [SW-1:0] sc;
  logic term;
`ifdef GHOST_SCHED_FREEZE_EN
  localparam int FW = $clog2(FREEZE_CYCLES + 1);
  logic [FW-1:0] fc;
`else
  logic unused_collision;
  assign unused_collision = bus.collision;
`endif
  assign period_calc = bus.speed_offset >= 26'(TIME_MAX - MIN_PERIOD) ? PW'(MIN_PERIOD)
                     : PW'(TIME_MAX - int'(bus.speed_offset));
  // the period latched at count 0 must already govern that same cycle's terminal test
  assign cur_period = pc == '0 ? period_calc : period_q;
  assign term = pc == cur_period - PW'(1);
  assign sel_n = term ? N_GHOSTS'(1) : sel << 1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      active <= '0;
      tick <= '0;
      sel <= '0;
      pc <= '0;
      period_q <= '0;
      sc <= '0;
`ifdef GHOST_SCHED_FREEZE_EN
      fc <= '0;
`endif
    end else if (bus.stop) begin
      st <= IDLE;
      active <= '0;
      tick <= '0;
      sel <= '0;
      pc <= '0;
      period_q <= '0;
      sc <= '0;
`ifdef GHOST_SCHED_FREEZE_EN
      fc <= '0;
    end else if (st == RUN && bus.collision) begin
      st <= FREEZE;
      fc <= '0;
      sel <= '0;
      tick <= '0;
    end else if (st == FREEZE) begin
      st <= fc == FW'(FREEZE_CYCLES - 1) ? RUN : FREEZE;
      fc <= fc + 1'b1;
`endif
    end else if (st == IDLE) begin
      if (bus.start) begin
        st <= SPAWN;
        active <= '0;
        sc <= '0;
        pc <= '0;
      end
    end else begin
      pc <= term ? '0 : pc + 1'b1;
      if (pc == '0) period_q <= period_calc;
      sel <= sel_n;
      tick <= sel_n & active;
      if (st == SPAWN) begin
        if (active == '0) begin
          active <= N_GHOSTS'(1);
          sc <= '0;
        end else if (active[N_GHOSTS-1]) st <= RUN;
        else if (sc == SW'(SPAWN_DELAY - 1)) begin
          active <= (active << 1) | N_GHOSTS'(1);
          sc <= '0;
        end else sc <= sc + 1'b1;
      end
    end
  end
  assign bus.move_tick = tick;
  assign bus.active = active;
  assign bus.state = st;
endmodule

// File: tb/tb_ghost_scheduler.sv
// tb_ghost_scheduler: directed vector table and randomized traffic checked against a behavioural model.
`timescale 1ns/1ps
module tb_ghost_scheduler;
  localparam int N = 3, TM = 20, MP = 4, SD = 10, FC = 8;
`ifdef GHOST_SCHED_FREEZE_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  ghost_scheduler_if #(.N_GHOSTS(N)) bus ();
  ghost_scheduler #(.N_GHOSTS(N), .TIME_MAX(TM), .MIN_PERIOD(MP), .SPAWN_DELAY(SD),
                    .FREEZE_CYCLES(FC)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  int m_st, m_act, m_tick, m_pc, m_per, m_age, m_fc;
  int m_q[$];
  typedef struct { bit s, p, c; int so, n, st, act, tick; } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int period_of(input int so);
    return so >= TM - MP ? MP : TM - so;
  endfunction

  task automatic m_reset();
    m_st = 0; m_act = 0; m_tick = 0; m_pc = 0; m_per = 0; m_age = 0; m_fc = 0;
    m_q.delete();
  endtask

  // Model: ghost i appears 1+i*SD cycles into SPAWN; a terminal count queues one tick slot per ghost.
  task automatic m_step(input bit s, input bit p, input bit c, input int so);
    int old_act, per, k;
    old_act = m_act;
    m_tick = 0;
    if (p) m_reset();
    else if (FE && m_st == 2 && c) begin
      m_st = 3; m_fc = 0; m_q.delete();
    end else if (m_st == 3) begin
      m_fc++;
      if (m_fc == FC) m_st = 2;
    end else if (m_st == 0) begin
      if (s) begin m_st = 1; m_age = 0; m_act = 0; m_pc = 0; end
    end else begin
      per = m_pc == 0 ? period_of(so) : m_per;
      m_per = per;
      if (m_pc == per - 1) begin
        m_pc = 0;
        m_q.delete();
        for (int g = 0; g < N; g++) m_q.push_back(g);
      end else m_pc++;
      if (m_q.size() > 0) begin
        k = m_q.pop_front();
        if (old_act[k]) m_tick = 1 << k;
      end
      if (m_st == 1) begin
        m_age++;
        for (int g = 0; g < N; g++) if (m_age == 1 + g * SD) m_act |= 1 << g;
        if (m_age == 2 + (N - 1) * SD) m_st = 2;
      end
    end
  endtask

  task automatic step(input bit s, input bit p, input bit c, input int so);
    bus.start = s; bus.stop = p; bus.collision = c; bus.speed_offset = 26'(so);
    @(posedge clk);
    m_step(s, p, c, so);
    cyc++;
    #1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.collision = 1'b0;
    chk("model state", int'(bus.state), m_st);
    chk("model active", int'(bus.active), m_act);
    chk("model move_tick", int'(bus.move_tick), m_tick);
  endtask

  initial begin
    int so;
    bus.start = 1'b0; bus.stop = 1'b0; bus.collision = 1'b0; bus.speed_offset = '0;
    m_reset();
    // start, stop, collision, speed_offset, steps, state, active, move_tick
    v.push_back('{1, 0, 0, 0, 1, 1, 0, 0});
    v.push_back('{0, 0, 0, 0, 1, 1, 1, 0});
    v.push_back('{0, 0, 0, 0, 10, 1, 3, 0});
    v.push_back('{0, 0, 0, 0, 9, 1, 3, 1});
    v.push_back('{0, 0, 0, 0, 1, 1, 7, 2});
    v.push_back('{0, 0, 0, 0, 1, 2, 7, 4});
    v.push_back('{0, 0, 0, 0, 1, 2, 7, 0});
    v.push_back('{0, 0, 0, 0, 17, 2, 7, 1});
    v.push_back('{0, 0, 0, 18, 1, 2, 7, 2});
    v.push_back('{0, 0, 0, 18, 1, 2, 7, 4});
    v.push_back('{0, 0, 0, 18, 2, 2, 7, 1});
    v.push_back('{0, 0, 0, 18, 1, 2, 7, 2});
    v.push_back('{0, 0, 0, 18, 1, 2, 7, 4});
    v.push_back('{0, 0, 0, 18, 2, 2, 7, 1});
    v.push_back('{0, 0, 0, 0, 1, 2, 7, 2});
    v.push_back('{0, 0, 0, 0, 6, 2, 7, 0});
    v.push_back('{0, 0, 0, 10, 3, 2, 7, 0});
    v.push_back('{0, 0, 0, 10, 10, 2, 7, 1});
    v.push_back('{0, 0, 0, 10, 10, 2, 7, 1});
    v.push_back('{0, 0, 1, 10, 1, FE ? 3 : 2, 7, FE ? 0 : 2});
    v.push_back('{0, 0, 0, 10, 7, FE ? 3 : 2, 7, 0});
    v.push_back('{0, 0, 0, 10, 1, 2, 7, 0});
    v.push_back('{0, 0, 0, 10, 1, 2, 7, FE ? 0 : 1});
    v.push_back('{0, 0, 0, 10, 9, 2, 7, FE ? 1 : 0});
    v.push_back('{0, 1, 1, 10, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 10, 25, 0, 0, 0});
    #12;
    chk("reset state", int'(bus.state), 0);
    chk("reset active", int'(bus.active), 0);
    chk("reset move_tick", int'(bus.move_tick), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step(0, 0, 0, 0);
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].s, v[i].p, v[i].c, v[i].so);
      for (int j = 1; j < v[i].n; j++) step(0, 0, 0, v[i].so);
      chk($sformatf("vec%0d state", i), int'(bus.state), v[i].st);
      chk($sformatf("vec%0d active", i), int'(bus.active), v[i].act);
      chk($sformatf("vec%0d move_tick", i), int'(bus.move_tick), v[i].tick);
    end
    // asynchronous reset in the middle of SPAWN
    step(1, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0);
    chk("pre-reset active", int'(bus.active), 3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async reset state", int'(bus.state), 0);
    chk("async reset active", int'(bus.active), 0);
    chk("async reset move_tick", int'(bus.move_tick), 0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) step(0, 0, 0, 0);
    so = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) so = $urandom_range(0, 25);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, so);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ghost_scheduler.md
GHOST_SCHEDULER -- requirements
Module: ghost_scheduler

Interface
REQ-001 SHALL have parameter N_GHOSTS, default 3, number of ghost sprites sequenced.
REQ-002 SHALL have parameter TIME_MAX, default 4000000, base move period in clk cycles.
REQ-003 SHALL have parameter MIN_PERIOD, default 1000, floor on move period (SHALL be >= N_GHOSTS).
REQ-004 SHALL have parameter SPAWN_DELAY, default 25000000, cycles between successive ghost activations.
REQ-005 SHALL have parameter FREEZE_CYCLES, default 50000000, freeze duration after collision.
REQ-006 SHALL have ports: clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: start  input  1  one-cycle pulse, begin game sequencing.
REQ-009 SHALL have ports: stop  input  1  one-cycle pulse, abort to idle.
REQ-010 SHALL have ports: collision  input  1  one-cycle pulse, yoshi/ghost contact.
REQ-011 SHALL have ports: speed_offset  input  26  score-dependent period reduction.
REQ-012 SHALL have ports: move_tick  output  N_GHOSTS  one-cycle per-ghost position-update strobes.
REQ-013 SHALL have ports: active  output  N_GHOSTS  ghost enabled/visible mask.
REQ-014 SHALL have ports: state  output  2  FSM state: 0 IDLE, 1 SPAWN, 2 RUN, 3 FREEZE.

Function
REQ-015 SHALL transition IDLE->SPAWN on start; active cleared, spawn counter cleared, period counter cleared.
REQ-016 SHALL in SPAWN set active[0] on entry cycle +1, then set next bit (ascending index) every SPAWN_DELAY cycles; when bit N_GHOSTS-1 is set, go to RUN next cycle.
REQ-017 SHALL compute period = MIN_PERIOD if speed_offset >= TIME_MAX-MIN_PERIOD, else TIME_MAX-speed_offset (no underflow).
REQ-018 SHALL latch period only when the period counter is at 0; mid-period speed_offset changes take effect next period.
REQ-019 SHALL run the period counter 0..period-1 in SPAWN and RUN; hold it in IDLE (at 0) and FREEZE (held value).
REQ-020 SHALL on counter == period-1 start a burst: on burst cycle k (k=0..N_GHOSTS-1, k=0 is the cycle after terminal count), assert move_tick[k] iff active[k].
REQ-021 SHALL assert at most one move_tick bit per cycle; move_tick SHALL be 0 outside bursts.
REQ-022 SHALL enter FREEZE from RUN on collision; remaining burst ticks dropped; freeze counter cleared.
REQ-023 SHALL ignore collision in IDLE, SPAWN and FREEZE (no freeze extension).
REQ-024 SHALL return FREEZE->RUN after exactly FREEZE_CYCLES cycles; period counter resumes from held value.
REQ-025 SHALL on stop in any state go to IDLE next cycle, clear active, all counters, and any burst.
REQ-026 SHALL prioritise same-cycle inputs: stop > collision > start; start ignored outside IDLE.
REQ-027 SHALL keep active unchanged in RUN and FREEZE.

Reset
REQ-028 SHALL on reset_n low asynchronously force state=IDLE, active=0, move_tick=0, all counters and latched period to 0.
REQ-029 SHALL require start after reset release; no ticks until then.

Configuration
REQ-030 SHALL compile freeze logic only when GHOST_SCHED_FREEZE_EN is defined; with it, REQ-022..024 apply.
REQ-031 SHALL without GHOST_SCHED_FREEZE_EN ignore collision, never enter state 3, and omit freeze counter.

Verification (N_GHOSTS=3, TIME_MAX=20, MIN_PERIOD=4, SPAWN_DELAY=10, FREEZE_CYCLES=8)
REQ-032 SHALL cover: start pulse, speed_offset=0 -> active 001, 011 after 10 cycles, 111 after 20; state 2 next cycle; ticks every 20 cycles.
REQ-033 SHALL cover: RUN, speed_offset=18 -> period clamped to 4; ticks 001,010,100 on consecutive cycles, burst repeats every 4 cycles.
REQ-034 SHALL cover: RUN, speed_offset 0->10 mid-period -> current period stays 20, next period 10.
REQ-035 SHALL cover: collision on burst cycle 1 -> ticks 010,100 dropped; state 3 for 8 cycles; counter resumes from held value (macro defined); macro undefined -> no effect.
REQ-036 SHALL cover: stop and collision same cycle in RUN -> state 0, active 000, no further ticks; reset_n low mid-SPAWN -> all outputs 0 immediately.
